// File: rtl/tl_a_arbiter_if.sv
// TileLink-style A/D channel bundle. A requester drives the master side;
// the arbiter presents the slave side to each requester.
interface tl_a_arbiter_if #(parameter int SRC_W = 4);
  logic             a_valid;
  logic             a_ready;
  logic [2:0]       a_opcode;
  logic [2:0]       a_param;
  logic [2:0]       a_size;
  logic [SRC_W-1:0] a_source;
  logic [31:0]      a_address;
  logic [7:0]       a_mask;
  logic [63:0]      a_data;
  logic             a_corrupt;

  logic             d_valid;
  logic             d_ready;
  logic [2:0]       d_opcode;
  logic [2:0]       d_size;
  logic [SRC_W-1:0] d_source;
  logic             d_denied;
  logic [63:0]      d_data;
  logic             d_corrupt;

  modport master (
    output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt,
    input  a_ready,
    input  d_valid, d_opcode, d_size, d_source, d_denied, d_data, d_corrupt,
    output d_ready
  );

  modport slave (
    input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt,
    output a_ready,
    output d_valid, d_opcode, d_size, d_source, d_denied, d_data, d_corrupt,
    input  d_ready
  );
endinterface

// File: rtl/tl_a_arbiter.sv
// Two-requester A-channel round-robin arbiter with burst locking, plus
// combinational D-channel routing on the top source bit.
//
// state | meaning
// IDLE  | free; grant chosen combinationally (round-robin on a tie)
// HOLD  | granted beat stalled by out_a_ready=0; grant frozen until it fires
// BURST | multi-beat Put in progress; grant locked, cnt_q = beats still owed
module tl_a_arbiter (
  input  logic          clock,
  input  logic          reset,
  tl_a_arbiter_if.slave  in0,
  tl_a_arbiter_if.slave  in1,
  tl_a_arbiter_if.master out
);
  typedef enum logic [1:0] {IDLE, HOLD, BURST} state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       grant_q, grant_d;
  logic       last_q, last_d;
  logic       grant;
  logic       fire;
  logic       multi;
  logic [4:0] beats;
  logic [3:0] beats_m1;
  logic       d_sel;

  always_comb begin
    grant = grant_q;
    if (state_q == IDLE) begin
      if (in0.a_valid && in1.a_valid) grant = ~last_q;
      else                            grant = in1.a_valid;
    end
  end

  always_comb begin
    out.a_valid   = grant ? in1.a_valid   : in0.a_valid;
    out.a_opcode  = grant ? in1.a_opcode  : in0.a_opcode;
    out.a_param   = grant ? in1.a_param   : in0.a_param;
    out.a_size    = grant ? in1.a_size    : in0.a_size;
    out.a_source  = {grant, (grant ? in1.a_source : in0.a_source)};
    out.a_address = grant ? in1.a_address : in0.a_address;
    out.a_mask    = grant ? in1.a_mask    : in0.a_mask;
    out.a_data    = grant ? in1.a_data    : in0.a_data;
    out.a_corrupt = grant ? in1.a_corrupt : in0.a_corrupt;
    in0.a_ready   = ~grant & out.a_ready;
    in1.a_ready   = grant & out.a_ready;
  end

  // beats = 2^(size-3); a 16-beat burst wraps beats[3:0] to 0, so beats-1 is still 15
  assign fire     = out.a_valid & out.a_ready;
  assign multi    = ((out.a_opcode == 3'd0) || (out.a_opcode == 3'd1)) && (out.a_size > 3'd3);
  assign beats    = 5'd1 << (out.a_size - 3'd3);
  assign beats_m1 = beats[3:0] - 4'd1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    last_d  = last_q;
    if (fire) last_d = grant;
    case (state_q)
      IDLE: begin
        grant_d = grant;
        if (fire) begin
          if (multi) begin
            state_d = BURST;
            cnt_d   = beats_m1;
          end
        end else if (out.a_valid) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (fire) begin
          if (multi) begin
            state_d = BURST;
            cnt_d   = beats_m1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      BURST: begin
        if (fire) begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign d_sel = out.d_source[4];

  always_comb begin
    in0.d_valid   = out.d_valid & ~d_sel;
    in1.d_valid   = out.d_valid & d_sel;
    in0.d_opcode  = out.d_opcode;
    in1.d_opcode  = out.d_opcode;
    in0.d_size    = out.d_size;
    in1.d_size    = out.d_size;
    in0.d_source  = out.d_source[3:0];
    in1.d_source  = out.d_source[3:0];
    in0.d_denied  = out.d_denied;
    in1.d_denied  = out.d_denied;
    in0.d_data    = out.d_data;
    in1.d_data    = out.d_data;
    in0.d_corrupt = out.d_corrupt;
    in1.d_corrupt = out.d_corrupt;
    out.d_ready   = d_sel ? in1.d_ready : in0.d_ready;
  end
endmodule

// File: tb/tb_tl_a_arbiter.sv
// Scoreboard bench for tl_a_arbiter: a message-level reference model predicts
// grants and pushes expected A beats; a monitor pops them on every downstream fire.
module tb_tl_a_arbiter;
  typedef struct packed {
    logic [2:0]  opcode;
    logic [2:0]  param;
    logic [2:0]  size;
    logic [3:0]  source;
    logic [31:0] address;
    logic [7:0]  mask;
    logic [63:0] data;
    logic        corrupt;
  } beat_t;

  typedef struct packed {
    logic  idx;
    beat_t b;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;

  tl_a_arbiter_if #(.SRC_W(4)) in0_bus ();
  tl_a_arbiter_if #(.SRC_W(4)) in1_bus ();
  tl_a_arbiter_if #(.SRC_W(5)) out_bus ();

  tl_a_arbiter dut (
    .clock (clock),
    .reset (reset),
    .in0   (in0_bus),
    .in1   (in1_bus),
    .out   (out_bus)
  );

  always #5 clock = ~clock;

  exp_t  expq[$];
  beat_t pend[2][$];
  beat_t cur[2];
  bit    v[2];
  bit    took[2];
  bit    rdy;
  bit    rst_drv;
  logic [4:0] obs_src;
  logic       obs_fire;

  // reference model: owner lock, beats still owed, last granted requester
  int m_last = 1;
  bit m_lock = 0;
  int m_idx  = 0;
  bit m_burst = 0;
  int m_left = 0;

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic checkw(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic beat_t mk(input logic [2:0] op, input logic [2:0] sz, input logic [3:0] src);
    beat_t b;
    b.opcode  = op;
    b.param   = 3'($urandom_range(0, 7));
    b.size    = sz;
    b.source  = src;
    b.address = $urandom;
    b.mask    = 8'($urandom);
    b.data    = {$urandom, $urandom};
    b.corrupt = 1'($urandom_range(0, 1));
    return b;
  endfunction

  function automatic bit is_multi(input beat_t b);
    return ((b.opcode == 3'd0) || (b.opcode == 3'd1)) && (b.size > 3'd3);
  endfunction

  function automatic int nbeats(input beat_t b);
    return is_multi(b) ? (1 << (int'(b.size) - 3)) : 1;
  endfunction

  task automatic gen_msg(input int n);
    logic [2:0] op;
    logic [2:0] sz;
    logic [3:0] src;
    int nb;
    op  = 3'($urandom_range(0, 5));
    sz  = 3'($urandom_range(0, 7));
    src = 4'($urandom);
    nb  = nbeats(mk(op, sz, src));
    for (int k = 0; k < nb; k++) pend[n].push_back(mk(op, sz, src));
  endtask

  task automatic d_drive_check(input logic [4:0] src, input bit dv, input bit r0, input bit r1);
    logic [63:0] dd;
    logic [2:0]  dop, dsz;
    logic        den, dcor;
    bit          sel;
    dd   = {$urandom, $urandom};
    dop  = 3'($urandom_range(0, 7));
    dsz  = 3'($urandom_range(0, 7));
    den  = 1'($urandom_range(0, 1));
    dcor = 1'($urandom_range(0, 1));
    out_bus.d_valid   = dv;
    out_bus.d_source  = src;
    out_bus.d_opcode  = dop;
    out_bus.d_size    = dsz;
    out_bus.d_denied  = den;
    out_bus.d_data    = dd;
    out_bus.d_corrupt = dcor;
    in0_bus.d_ready   = r0;
    in1_bus.d_ready   = r1;
    #1;
    sel = src[4];
    check1("d_valid0", in0_bus.d_valid, dv && !sel);
    check1("d_valid1", in1_bus.d_valid, dv && sel);
    checkw("d_source0", 128'(in0_bus.d_source), 128'(src[3:0]));
    checkw("d_source1", 128'(in1_bus.d_source), 128'(src[3:0]));
    checkw("d_fields0", 128'({in0_bus.d_opcode, in0_bus.d_size, in0_bus.d_denied, in0_bus.d_data, in0_bus.d_corrupt}),
           128'({dop, dsz, den, dd, dcor}));
    checkw("d_fields1", 128'({in1_bus.d_opcode, in1_bus.d_size, in1_bus.d_denied, in1_bus.d_data, in1_bus.d_corrupt}),
           128'({dop, dsz, den, dd, dcor}));
    check1("d_ready", out_bus.d_ready, sel ? r1 : r0);
  endtask

  task automatic step();
    int g;
    bit efire;
    @(negedge clock);
    reset = rst_drv;
    in0_bus.a_valid   = v[0];
    in0_bus.a_opcode  = cur[0].opcode;
    in0_bus.a_param   = cur[0].param;
    in0_bus.a_size    = cur[0].size;
    in0_bus.a_source  = cur[0].source;
    in0_bus.a_address = cur[0].address;
    in0_bus.a_mask    = cur[0].mask;
    in0_bus.a_data    = cur[0].data;
    in0_bus.a_corrupt = cur[0].corrupt;
    in1_bus.a_valid   = v[1];
    in1_bus.a_opcode  = cur[1].opcode;
    in1_bus.a_param   = cur[1].param;
    in1_bus.a_size    = cur[1].size;
    in1_bus.a_source  = cur[1].source;
    in1_bus.a_address = cur[1].address;
    in1_bus.a_mask    = cur[1].mask;
    in1_bus.a_data    = cur[1].data;
    in1_bus.a_corrupt = cur[1].corrupt;
    out_bus.a_ready   = rdy;
    d_drive_check(5'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    if (!rst_drv) begin
      m_last = 1; m_lock = 0; m_burst = 0; m_left = 0;
    end
    if (m_lock)          g = m_idx;
    else if (v[0] && v[1]) g = 1 - m_last;
    else if (v[1])       g = 1;
    else                 g = 0;
    efire = v[g] && rdy;

    check1("in0_a_ready", in0_bus.a_ready, (g == 0) && rdy);
    check1("in1_a_ready", in1_bus.a_ready, (g == 1) && rdy);
    check1("out_a_valid", out_bus.a_valid, v[g]);
    obs_src  = out_bus.a_source;
    obs_fire = out_bus.a_valid & out_bus.a_ready;

    took[0] = 0;
    took[1] = 0;
    if (efire) begin
      expq.push_back({(g == 1), cur[g]});
      took[g] = 1;
      if (rst_drv) begin
        m_last = g;
        if (m_burst) begin
          m_left--;
          if (m_left == 0) begin
            m_burst = 0;
            m_lock  = 0;
          end
        end else if (is_multi(cur[g])) begin
          m_burst = 1; m_lock = 1; m_idx = g; m_left = nbeats(cur[g]) - 1;
        end else begin
          m_lock = 0;
        end
      end
    end else if (rst_drv && v[g] && !m_lock) begin
      m_lock = 1;
      m_idx  = g;
    end
  endtask

  task automatic clear_took();
    for (int n = 0; n < 2; n++) if (took[n]) v[n] = 0;
  endtask

  task automatic idle_step();
    v[0] = 0; v[1] = 0; rdy = 0;
    step();
  endtask

  initial begin
    exp_t e;
    exp_t got;
    forever begin
      @(negedge clock);
      #2;
      if (out_bus.a_valid === 1'b1 && out_bus.a_ready === 1'b1) begin
        got = {out_bus.a_source[4], out_bus.a_opcode, out_bus.a_param, out_bus.a_size, out_bus.a_source[3:0],
               out_bus.a_address, out_bus.a_mask, out_bus.a_data, out_bus.a_corrupt};
        if (expq.size() == 0) begin
          checkw("a_beat_unexpected", 128'(got), 128'(0));
        end else begin
          e = expq.pop_front();
          checkw("a_beat", 128'(got), 128'(e));
        end
      end
    end
  end

  initial begin
    rst_drv = 0; v[0] = 0; v[1] = 0; rdy = 0;
    cur[0] = mk(3'd4, 3'd2, 4'h0);
    cur[1] = mk(3'd4, 3'd2, 4'h0);
    step();
    // grant and ready stay combinational while reset is held
    cur[0] = mk(3'd4, 3'd2, 4'h5); v[0] = 1; rdy = 1;
    step(); clear_took();
    idle_step();
    rst_drv = 1;
    idle_step();

    // round-robin on back-to-back ties
    for (int i = 0; i < 4; i++) begin
      cur[0] = mk(3'd4, 3'd2, 4'h1); cur[1] = mk(3'd4, 3'd2, 4'h2);
      v[0] = 1; v[1] = 1; rdy = 1;
      step();
      check1("rr_src4", obs_src[4], (i % 2) == 1);
      clear_took();
    end

    // 8-beat PutFull from in0 locks out in1
    cur[1] = mk(3'd4, 3'd2, 4'h4); v[1] = 1; rdy = 1;
    for (int k = 0; k < 8; k++) begin
      cur[0] = mk(3'd0, 3'd6, 4'h3); v[0] = 1;
      step();
      check1("burst_in0", obs_fire && !obs_src[4], 1'b1);
      clear_took();
    end
    step();
    check1("after_burst_in1", obs_fire && obs_src[4], 1'b1);
    clear_took();

    // stalled in1 Get keeps its grant while in0 arrives
    cur[1] = mk(3'd4, 3'd1, 4'h7); v[1] = 1; rdy = 0;
    step();
    cur[0] = mk(3'd4, 3'd1, 4'h8); v[0] = 1;
    step();
    step();
    rdy = 1;
    step();
    check1("hold_in1_fires", obs_fire && obs_src[4], 1'b1);
    clear_took();
    step();
    check1("hold_then_in0", obs_fire && !obs_src[4], 1'b1);
    clear_took();

    // size=3 PutFull is single-beat: no lock afterwards
    cur[0] = mk(3'd0, 3'd3, 4'h9); v[0] = 1; v[1] = 0; rdy = 1;
    step(); clear_took();
    cur[0] = mk(3'd4, 3'd2, 4'ha); cur[1] = mk(3'd4, 3'd2, 4'hb); v[0] = 1; v[1] = 1;
    step();
    check1("single_no_lock", obs_fire && obs_src[4], 1'b1);
    clear_took();
    step(); clear_took();

    // reset after 3 of 4 PutPartial beats aborts the burst
    for (int k = 0; k < 3; k++) begin
      cur[0] = mk(3'd1, 3'd5, 4'hc); v[0] = 1; v[1] = 0; rdy = 1;
      step(); clear_took();
    end
    rst_drv = 0;
    idle_step();
    idle_step();
    rst_drv = 1;
    cur[1] = mk(3'd4, 3'd2, 4'hd); v[1] = 1; v[0] = 0; rdy = 1;
    step();
    check1("post_reset_in1", obs_fire && obs_src[4], 1'b1);
    clear_took();
    idle_step();

    // D routing on source[4]
    @(negedge clock);
    d_drive_check(5'b1_0110, 1'b1, 1'b0, 1'b1);
    d_drive_check(5'b1_0110, 1'b1, 1'b1, 1'b0);
    d_drive_check(5'b0_0011, 1'b1, 1'b1, 1'b0);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      for (int n = 0; n < 2; n++) begin
        if (pend[n].size() == 0) gen_msg(n);
        if (!v[n] && $urandom_range(0, 3) != 0) begin
          cur[n] = pend[n].pop_front();
          v[n] = 1;
        end
      end
      rdy = ($urandom_range(0, 3) != 0);
      step();
      clear_took();
    end

    idle_step();
    idle_step();
    checkw("scoreboard_empty", 128'(expq.size()), 128'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
